// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SRL = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    SHIFT = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int ST_Z   = 0;
  localparam int ST_N   = 1;
  localparam int ST_C   = 2;
  localparam int ST_V   = 3;
  localparam int ST_ILL = 4;

  // Assemble the status word from individual flags.
  function automatic logic [4:0] pack_status(input logic ill, input logic v,
                                             input logic c, input logic n,
                                             input logic z);
    logic [4:0] s;
    s         = '0;
    s[ST_ILL] = ill;
    s[ST_V]   = v;
    s[ST_C]   = c;
    s[ST_N]   = n;
    s[ST_Z]   = z;
    return s;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == OP_SRL) || (code == OP_SLL) || (code == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle part of the ALU: logic ops, add/sub/slt and their flags.
// Any code it does not handle is reported as illegal (result 0, ILL=1, Z=1).
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       status
);

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  // Shared adder: subtraction is a + ~b + 1; overflow when the adder's
  // operands agree in sign but the sum does not.
  always_comb begin
    is_sub  = (op == OP_SUB) || (op == OP_SLT);
    b_op    = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    sum     = sum_ext[WIDTH-1:0];
    carry   = sum_ext[WIDTH];
    ovf     = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Select result and flags per operation.
  always_comb begin
    logic c_f;
    logic v_f;
    logic ill_f;
    result = '0;
    c_f    = 1'b0;
    v_f    = 1'b0;
    ill_f  = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD, OP_SUB: begin
        result = sum;
        c_f    = carry;
        v_f    = ovf;
      end
      OP_SLT: begin
        result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        c_f    = carry;
        v_f    = ovf;
      end
      default: ill_f = 1'b1;
    endcase
    status = pack_status(ill_f, v_f, c_f, result[WIDTH-1], result == '0);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops go
// through alu_comb; shifts move one bit per cycle and the multiply is an
// iterative shift-add into a double-width accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, and out_valid holds result and
// status stable in DONE until out_ready is seen.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       status
);

  // Counter must hold WIDTH for the multiply, one bit wider than shamt.
  localparam int CW = SHW + 1;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic               sh_c;
  logic [WIDTH-1:0]   comb_result;
  logic [4:0]         comb_status;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (comb_result),
    .status (comb_status)
  );

  // Control FSM and datapath registers; b_q doubles as the shift value and
  // the multiplier that is consumed LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      sh_c      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            sh_c     <= 1'b0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a};
            in_ready <= 1'b0;
            if (is_shift_op(op)) begin
              cnt   <= CW'(shamt);
              state <= SHIFT;
            end else if (op == OP_MUL) begin
              cnt   <= CW'(WIDTH);
              state <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          result    <= comb_result;
          status    <= comb_status;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        SHIFT: begin
          if (cnt == '0) begin
            result    <= b_q;
            status    <= pack_status(1'b0, 1'b0, sh_c, b_q[WIDTH-1], b_q == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
            case (op_q)
              OP_SLL: begin
                sh_c <= b_q[WIDTH-1];
                b_q  <= {b_q[WIDTH-2:0], 1'b0};
              end
              OP_SRA: begin
                sh_c <= b_q[0];
                b_q  <= {b_q[WIDTH-1], b_q[WIDTH-1:1]};
              end
              default: begin
                sh_c <= b_q[0];
                b_q  <= {1'b0, b_q[WIDTH-1:1]};
              end
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            result    <= acc[WIDTH-1:0];
            status    <= pack_status(1'b0, |acc[2*WIDTH-1:WIDTH], 1'b0,
                                     acc[WIDTH-1], acc[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (b_q[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            b_q   <= b_q >> 1;
            cnt   <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc against an arithmetic model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  status;

  int tests  = 0;
  int failed = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model from the operation definitions, using wide signed math.
  function automatic void model(input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y, input logic [4:0] s,
                                output logic [31:0] r, output logic [4:0] st,
                                output int lat);
    longint sx;
    longint sy;
    longint t;
    logic [63:0] u;
    logic c;
    logic v;
    logic ill;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    r   = '0;
    lat = 2;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        u = {32'h0, x} + {32'h0, y};
        r = u[31:0];
        c = u[32];
        t = sx + sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd6, 4'd7: begin
        c = (x >= y);
        t = sx - sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        r = (o == 4'd6) ? (x - y) : ((sx < sy) ? 32'd1 : 32'd0);
      end
      4'd3: begin
        r = y >> s;
        c = (s == 0) ? 1'b0 : y[int'(s) - 1];
        lat = int'(s) + 2;
      end
      4'd4: begin
        r = y << s;
        c = (s == 0) ? 1'b0 : y[32 - int'(s)];
        lat = int'(s) + 2;
      end
      4'd5: begin
        r = $signed(y) >>> s;
        c = (s == 0) ? 1'b0 : y[int'(s) - 1];
        lat = int'(s) + 2;
      end
      4'd8: begin
        u = {32'h0, x} * {32'h0, y};
        r = u[31:0];
        v = (u[63:32] != 0);
        lat = 34;
      end
      default: ill = 1'b1;
    endcase
    st = {ill, v, c, r[31], r == 32'h0};
  endfunction

  // Driver: issue one op, check latency/result/status, optionally stall the
  // consumer for `hold` cycles while poking in_valid, then complete.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input int hold);
    logic [31:0] er;
    logic [4:0]  es;
    int          el;
    int          lat;
    int          g;
    model(o, x, y, s, er, es, el);
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom); op = 4'($urandom);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, result, er);
    chk({tag, "_st"}, status, es);
    chk({tag, "_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'($urandom); a = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_ov"}, out_valid, 1);
      chk({tag, "_hold_res"}, result, er);
      chk({tag, "_hold_st"}, status, es);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  // scoreboard-free directed + random sequence
  initial begin
    int seen;
    logic [3:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0; out_ready = 1'b1;
    #12;
    chk("rst_ov", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_st", status, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready, 1);

    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
    run_op("sub_eq", 4'd6, 32'd5, 32'd5, 5'd0, 0);
    run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    run_op("sra4", 4'd5, 32'h3, 32'h8000_0010, 5'd4, 0);
    run_op("srl0", 4'd3, 32'h0, 32'hDEAD_BEEF, 5'd0, 0);
    run_op("sll31", 4'd4, 32'h0, 32'h0000_0003, 5'd31, 0);
    run_op("mul_big", 4'd8, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    run_op("mul_small", 4'd8, 32'd7, 32'd6, 5'd0, 0);
    run_op("and_hold", 4'd0, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 5);
    run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 5'd3, 0);
    run_op("or", 4'd1, 32'h0F00_0000, 32'h0000_00F0, 5'd0, 0);

    // reset in the middle of a multiply
    @(negedge clk);
    op = 4'd8; a = 32'd9; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_res", result, 0);
    chk("mrst_st", status, 0);
    chk("mrst_rdy", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_out", seen, 0);
    chk("mrst_rdy_after", in_ready, 1);

    // randomized ops, including illegal codes and corner operands
    for (int n = 0; n < 30; n++) begin
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rx = $urandom;
        1: rx = 32'h7FFF_FFFF;
        2: rx = 32'h8000_0000;
        default: rx = 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = 32'hFFFF_FFFF;
        2: ry = rx;
        default: ry = 32'($urandom_range(0, 3));
      endcase
      run_op("rnd", ro, rx, ry, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
